// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin scheduler sharing one async-FIFO write port among
// N_SRC requesters; each written word carries the granted source ID in its MSBs.
module fifo_wr_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16,
  parameter int THROTTLE  = 1,
  localparam int ID_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                      wr_clk,
  input  logic                      wr_rstn,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  input  logic [N_SRC-1:0]          src_last,
  output logic [N_SRC-1:0]          src_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [ID_W+DATA_W-1:0]    fifo_wr_data,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      err_timeout,
  output logic [15:0]               pkt_cnt
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic              err_q, err_d;
  logic              gap_q, gap_d;

  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   next_ptr;
  logic              any_valid;
  logic              is_busy;
  logic              ok;
  logic              beat;
  logic              cur_valid;
  logic              cur_last;
  logic [DATA_W-1:0] cur_data;

  // Scan downward so the requester closest to rr_ptr (cyclically) wins last.
  always_comb begin
    int idx;
    idx       = 0;
    pick      = rr_ptr_q;
    any_valid = 1'b0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % N_SRC;
      if (src_valid[idx]) begin
        pick      = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == ID_W'(i)) begin
        cur_valid = src_valid[i];
        cur_last  = src_last[i];
        cur_data  = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // The gap cycle after each write hides the FIFO's registered-full lag.
  assign is_busy  = (state_q == BUSY);
  assign ok       = !fifo_full && !((THROTTLE != 0) && gap_q);
  assign beat     = is_busy && cur_valid && ok;
  assign next_ptr = (grant_q == ID_W'(N_SRC - 1)) ? '0 : grant_q + 1'b1;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ready
      assign src_ready[gi] = is_busy && ok && (grant_q == ID_W'(gi));
    end
  endgenerate

  assign fifo_wr_en   = beat;
  assign fifo_wr_data = is_busy ? {grant_q, cur_data} : '0;
  assign grant_id     = grant_q;
  assign busy         = is_busy;
  assign err_timeout  = err_q;
  assign pkt_cnt      = pkt_cnt_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_d      = 1'b0;
    gap_d      = (THROTTLE != 0) && beat;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (cur_last) begin
            state_d    = IDLE;
            pkt_cnt_d  = pkt_cnt_q + 16'd1;
            rr_ptr_d   = next_ptr;
            beat_cnt_d = '0;
          end else if (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) begin
            // Forced release: the rest of the packet re-arbitrates as a new one.
            state_d    = IDLE;
            err_d      = 1'b1;
            rr_ptr_d   = next_ptr;
            beat_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      err_q      <= 1'b0;
      gap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_q      <= err_d;
      gap_q      <= gap_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: per-source beat queues feed the arbiter, a scoreboard queue
// holds the words expected on the FIFO write port in order.
module tb_fifo_wr_arbiter;

  logic        wr_clk = 1'b0;
  logic        wr_rstn;
  logic [3:0]  src_valid, src_last, src_ready;
  logic [31:0] src_data;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [9:0]  fifo_wr_data;
  logic [1:0]  grant_id;
  logic        busy, err_timeout;
  logic [15:0] pkt_cnt;

  // Second instance with THROTTLE=1 and its own reset.
  logic        t_rstn;
  logic [3:0]  t_valid, t_last, t_ready;
  logic [31:0] t_data;
  logic        t_full;
  logic        t_wr_en;
  logic [9:0]  t_wr_data;
  logic [1:0]  t_grant;
  logic        t_busy, t_err;
  logic [15:0] t_pkt;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(.N_SRC(4), .DATA_W(8), .MAX_BEATS(16), .THROTTLE(0)) u_dut (
    .wr_clk(wr_clk), .wr_rstn(wr_rstn), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant_id(grant_id),
    .busy(busy), .err_timeout(err_timeout), .pkt_cnt(pkt_cnt)
  );

  fifo_wr_arbiter #(.N_SRC(4), .DATA_W(8), .MAX_BEATS(16), .THROTTLE(1)) u_thr (
    .wr_clk(wr_clk), .wr_rstn(t_rstn), .src_valid(t_valid), .src_data(t_data),
    .src_last(t_last), .src_ready(t_ready), .fifo_full(t_full),
    .fifo_wr_en(t_wr_en), .fifo_wr_data(t_wr_data), .grant_id(t_grant),
    .busy(t_busy), .err_timeout(t_err), .pkt_cnt(t_pkt)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [8:0] srcq [4][$];
  logic [9:0] sb [$];
  logic [3:0] pause = 4'b0;

  // Values sampled at the falling edge of the most recent tick.
  logic       wr_s, busy_s, err_s, t_wr_s, t_busy_s;
  logic [1:0] grant_s, t_grant_s;
  logic [3:0] rdy_s;
  logic [9:0] t_data_s;
  int         wcount, err_cnt, wr_at_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (!pause[i] && srcq[i].size() > 0) begin
        src_valid[i]        = 1'b1;
        src_last[i]         = srcq[i][0][8];
        src_data[i*8 +: 8]  = srcq[i][0][7:0];
      end else begin
        src_valid[i]        = 1'b0;
        src_last[i]         = 1'b0;
        src_data[i*8 +: 8]  = 8'h00;
      end
    end
  endtask

  task automatic load(input int s, input int n, input logic [7:0] base, input bit with_last);
    logic [1:0] id;
    logic [7:0] d;
    id = 2'(s);
    for (int j = 0; j < n; j++) begin
      d = base + 8'(j);
      srcq[s].push_back({(with_last && j == n - 1), d});
      sb.push_back({id, d});
    end
  endtask

  task automatic tick();
    logic [3:0] acc;
    logic [9:0] exp_w;
    @(negedge wr_clk);
    acc       = src_valid & src_ready;
    wr_s      = fifo_wr_en;
    busy_s    = busy;
    err_s     = err_timeout;
    grant_s   = grant_id;
    rdy_s     = src_ready;
    t_wr_s    = t_wr_en;
    t_busy_s  = t_busy;
    t_grant_s = t_grant;
    t_data_s  = t_wr_data;
    check("ready_only_granted", src_ready & ~(4'b0001 << grant_id), 4'b0000);
    if (err_s) begin
      err_cnt++;
      wr_at_err = wcount;
    end
    if (fifo_wr_en) begin
      wcount++;
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        check("wr_data", fifo_wr_data, exp_w);
      end
    end
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) void'(srcq[i].pop_front());
    drive();
  endtask

  task automatic run_until_quiet(input string tag, input int budget);
    for (int c = 0; c < budget; c++) begin
      tick();
      if (sb.size() == 0 && !busy_s) break;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic run_until_writes(input string tag, input int n, input int budget);
    for (int c = 0; c < budget && wcount < n; c++) tick();
    check(tag, wcount, n);
  endtask

  initial begin
    wr_rstn = 1'b0; fifo_full = 1'b0; src_valid = '0; src_last = '0; src_data = '0;
    t_rstn = 1'b0; t_valid = '0; t_last = '0; t_data = '0; t_full = 1'b0;
    wcount = 0; err_cnt = 0; wr_at_err = 0;
    drive();
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_wr_data", fifo_wr_data, 0);
    check("rst_ready", src_ready, 0);
    wr_rstn = 1'b1; t_rstn = 1'b1;
    tick();
    check("post_rst_busy", busy_s, 0);
    check("post_rst_grant", grant_s, 0);
    check("post_rst_pkt", pkt_cnt, 0);
    check("post_rst_err", err_s, 0);

    // Single source, three beats.
    load(0, 3, 8'h11, 1);
    srcq[0][1][7:0] = 8'h22; srcq[0][2][7:0] = 8'h33;
    sb[1] = 10'h022; sb[2] = 10'h033;
    drive();
    tick();
    check("t1_arb_cycle_busy", busy_s, 0);
    check("t1_arb_cycle_wr", wr_s, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t1_consec_wr", wr_s, 1);
      check("t1_grant", grant_s, 0);
    end
    tick();
    check("t1_back_idle", busy_s, 0);
    check("t1_pkt_cnt", pkt_cnt, 1);
    check("t1_rr_ptr", u_dut.rr_ptr_q, 1);
    check("t1_sb_empty", sb.size(), 0);

    // Packet locking: src1 stalls mid-packet while src2 waits.
    wcount = 0;
    load(1, 4, 8'h41, 1);
    load(2, 2, 8'h51, 1);
    drive();
    run_until_writes("lock_first_two", 2, 20);
    pause[1] = 1'b1;
    drive();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("lock_hold_grant", grant_s, 1);
      check("lock_hold_busy", busy_s, 1);
      check("lock_no_write", wr_s, 0);
    end
    pause[1] = 1'b0;
    drive();
    run_until_quiet("lock_drain", 40);
    check("lock_pkt_cnt", pkt_cnt, 3);

    // Full backpressure mid-packet.
    wcount = 0;
    load(3, 6, 8'h61, 1);
    drive();
    run_until_writes("full_first_two", 2, 20);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("full_no_write", wr_s, 0);
      check("full_no_ready", rdy_s, 0);
      check("full_hold_busy", busy_s, 1);
    end
    fifo_full = 1'b0;
    run_until_quiet("full_drain", 40);
    check("full_pkt_cnt", pkt_cnt, 4);
    check("full_rr_ptr", u_dut.rr_ptr_q, 0);

    // Round-robin with 1-beat packets on every source.
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 4; s++) begin
        srcq[s].push_back({1'b1, 8'(8'hA0 + 8'(16 * r + s))});
        sb.push_back({2'(s), 8'(8'hA0 + 8'(16 * r + s))});
      end
    end
    drive();
    for (int k = 0; k < 16; k++) begin
      tick();
      check("rr_alternate", wr_s, 32'(k % 2));
      if (k % 2 == 1) check("rr_order", grant_s, 32'((k / 2) % 4));
    end
    check("rr_sb_empty", sb.size(), 0);
    check("rr_pkt_cnt", pkt_cnt, 12);

    // Timeout: 20 beats with no last from src3.
    wcount = 0; err_cnt = 0; wr_at_err = 0;
    load(3, 20, 8'h80, 0);
    drive();
    run_until_writes("to_twenty_writes", 20, 80);
    check("to_err_pulses", err_cnt, 1);
    check("to_writes_before_err", wr_at_err, 16);
    check("to_pkt_unchanged", pkt_cnt, 12);
    check("to_regrant", grant_s, 3);
    check("to_sb_empty", sb.size(), 0);

    // THROTTLE=1: src0 sends one-beat packets, src1 streams without last.
    t_data = 32'h34333231; t_last = 4'b0001; t_valid = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (t_busy_s && t_grant_s == 2'd1) break;
    end
    check("thr_grant_src1", t_grant_s, 1);
    check("thr_first_write", t_wr_s, 1);
    check("thr_pkt_cnt", t_pkt, 1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("thr_alternate", t_wr_s, 32'(k % 2 == 0));
    end
    t_rstn = 1'b0;
    #1;
    check("thr_rst_busy", t_busy, 0);
    check("thr_rst_wr_en", t_wr_en, 0);
    check("thr_rst_wr_data", t_wr_data, 0);
    check("thr_rst_ready", t_ready, 0);
    check("thr_rst_grant", t_grant, 0);
    check("thr_rst_pkt", t_pkt, 0);
    repeat (2) tick();
    check("thr_rst_held_busy", t_busy_s, 0);
    t_rstn = 1'b1;
    tick();
    check("thr_post_rst_idle", t_busy_s, 0);
    tick();
    check("thr_post_rst_busy", t_busy_s, 1);
    check("thr_post_rst_grant0", t_grant_s, 0);
    check("thr_post_rst_write", t_wr_s, 1);
    check("thr_post_rst_data", t_data_s, 10'h031);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side scheduler for the async FIFO. It shares one FIFO write port among N_SRC requesters using packet-level round-robin arbitration.
- Runs entirely in the wr_clk domain. It drives the FIFO's wr_en/wr_data and obeys its fifo_full flag.
- Each written word is tagged with the source ID in its MSBs, so the read side can demultiplex packets.

Parameters:
- N_SRC, 4, number of requesters (2..8); ID_W = clog2(N_SRC) is derived, not settable.
- DATA_W, 8, payload width per source.
- MAX_BEATS, 16, maximum beats per packet before forced release.
- THROTTLE, 1, 1 = at most one write every other cycle (covers the FIFO's registered-full lag); 0 = back-to-back writes.

Ports:
- wr_clk  in  1  write-domain clock.
- wr_rstn  in  1  asynchronous, active-low reset.
- src_valid  in  N_SRC  per-source beat valid.
- src_data  in  N_SRC*DATA_W  per-source payload, source i at [i*DATA_W +: DATA_W].
- src_last  in  N_SRC  per-source last beat of packet.
- src_ready  out  N_SRC  per-source beat accepted this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  ID_W+DATA_W  {grant_id, payload}.
- grant_id  out  ID_W  currently granted source.
- busy  out  1  a packet grant is held.
- err_timeout  out  1  one-cycle pulse on forced release.
- pkt_cnt  out  16  completed packets, wraps at 0xFFFF->0.

Behaviour:
- Reset (asynchronous, wr_rstn low) forces the following:
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, pkt_cnt=0, err_timeout=0, gap=0.
  - All outputs are 0, including src_ready, fifo_wr_en, fifo_wr_data and busy.
- FSM state IDLE:
  - busy=0 and src_ready=0.
  - If any src_valid is high, pick the first requester at or after rr_ptr in cyclic order.
  - Register that source into grant_id and go to BUSY. This costs one arbitration cycle before the first beat.
  - Grant is decided on src_valid alone; src_last is ignored at arbitration.
- FSM state BUSY:
  - busy=1.
  - Define ok = !fifo_full && !(THROTTLE && gap).
  - src_ready[grant_id] = ok. All other src_ready bits are 0.
  - beat = src_valid[grant_id] && ok.
  - fifo_wr_en = beat and fifo_wr_data = {grant_id, src_data[grant_id]}; both are combinational from registered state.
  - gap <= beat. gap is always 0 when THROTTLE=0.
  - On each beat, beat_cnt increments.
  - Beat with src_last=1: go to IDLE, pkt_cnt+1, rr_ptr <= grant_id+1 mod N_SRC, beat_cnt=0.
  - Beat with src_last=0 and beat_cnt==MAX_BEATS-1: forced release.
    - The beat is still written.
    - Go to IDLE, err_timeout=1 the next cycle only, rr_ptr advances, beat_cnt=0.
    - pkt_cnt does not increment.
    - The remainder of that source's packet is arbitrated later as a new packet.
- Grant is held for the whole packet. Other sources are never granted mid-packet, even while the holder has valid low.
- Full handling: while fifo_full is high, no write is issued and the grant is held; no data is lost or duplicated.
- A source dropping valid mid-packet stalls the port; there is no timeout on idle cycles.
- Reset mid-packet: the packet is abandoned immediately. The first post-reset grant starts from source 0.
- Single requester: that source is re-granted after each packet with a one-cycle IDLE bubble between packets.

Test Plan:
- Single source, N_SRC=4, THROTTLE=0:
  - Stimulus: src0 sends 3 beats 0x11,0x22,0x33 with last on the third.
  - Required: grant next cycle; fifo_wr_data = 0x011, 0x022, 0x033 on consecutive cycles; pkt_cnt=1; rr_ptr=1.
- Round-robin fairness:
  - Stimulus: all 4 sources hold 1-beat packets continuously.
  - Required: grant order is 0,1,2,3,0,...; each packet is separated by one IDLE cycle; after 8 packets pkt_cnt=8.
- Packet locking:
  - Stimulus: src1 sends a 4-beat packet with valid low on beat 2 for 3 cycles while src2 requests.
  - Required: src2 gets no grant until src1's last beat; no interleaved IDs appear in the FIFO.
- Full backpressure:
  - Stimulus: fifo_full high for 5 cycles mid-packet.
  - Required: fifo_wr_en=0 and src_ready=0 for those cycles; the beat sequence resumes intact with no dropped or duplicated words.
- Timeout:
  - Stimulus: MAX_BEATS=16, src3 streams 20 beats with no last.
  - Required: 16 words are written; err_timeout pulses once; pkt_cnt is unchanged; the arbiter re-arbitrates and src3's remaining 4 beats go out as a new grant.
- THROTTLE=1 and reset mid-packet:
  - Stimulus: continuous valid, then wr_rstn pulsed low mid-packet.
  - Required: writes occur only on alternate cycles. During reset all outputs are 0 immediately; after release, busy=0 and the first grant goes to source 0.
